// File: rtl/rs_issue_ctrl.sv
// Reservation-station scheduler for one execution unit.
// Optional build macro RS_OLDEST_FIRST_EN selects oldest-first issue.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module rs_issue_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int ENTRY_SEL = 3,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_x,
    input  logic                 flush,
    input  logic                 alloc_vld,
    output logic                 alloc_rdy,
    input  logic [`DATA_LEN-1:0] alloc_src1,
    input  logic                 alloc_rdy1,
    input  logic [`DATA_LEN-1:0] alloc_src2,
    input  logic                 alloc_rdy2,
    input  logic [`RRF_SEL-1:0]  alloc_dst,
    input  logic [PAYLOAD_W-1:0] alloc_payload,
    input  logic [`DATA_LEN-1:0] exrslt1,
    input  logic [`DATA_LEN-1:0] exrslt2,
    input  logic [`DATA_LEN-1:0] exrslt3,
    input  logic [`DATA_LEN-1:0] exrslt4,
    input  logic [`DATA_LEN-1:0] exrslt5,
    input  logic [`RRF_SEL-1:0]  exdst1,
    input  logic [`RRF_SEL-1:0]  exdst2,
    input  logic [`RRF_SEL-1:0]  exdst3,
    input  logic [`RRF_SEL-1:0]  exdst4,
    input  logic [`RRF_SEL-1:0]  exdst5,
    input  logic                 kill_spec1,
    input  logic                 kill_spec2,
    input  logic                 kill_spec3,
    input  logic                 kill_spec4,
    input  logic                 kill_spec5,
    output logic                 iss_vld,
    input  logic                 iss_rdy,
    output logic [`DATA_LEN-1:0] iss_src1,
    output logic [`DATA_LEN-1:0] iss_src2,
    output logic [`RRF_SEL-1:0]  iss_dst,
    output logic [PAYLOAD_W-1:0] iss_payload,
    output logic [ENTRY_SEL:0]   count
);
    localparam int DW = `DATA_LEN;
    localparam int TW = `RRF_SEL;
    localparam logic [ENTRY_SEL:0] CNT_FULL = ENTRY_NUM[ENTRY_SEL:0];

    logic [ENTRY_NUM-1:0] busy;
    logic [ENTRY_NUM-1:0] rdy1;
    logic [ENTRY_NUM-1:0] rdy2;
    logic [DW-1:0]        src1 [ENTRY_NUM];
    logic [DW-1:0]        src2 [ENTRY_NUM];
    logic [TW-1:0]        dst  [ENTRY_NUM];
    logic [PAYLOAD_W-1:0] pay  [ENTRY_NUM];
    logic [ENTRY_SEL:0]   count_q;

    logic [5*DW-1:0] bus_rslt;
    logic [5*TW-1:0] bus_dst;
    logic [4:0]      bus_live;

    assign bus_rslt = {exrslt5, exrslt4, exrslt3, exrslt2, exrslt1};
    assign bus_dst  = {exdst5, exdst4, exdst3, exdst2, exdst1};
    assign bus_live = ~{kill_spec5, kill_spec4, kill_spec3,
                        kill_spec2, kill_spec1};

    // Returns {hit, value}; the lowest-index live bus wins.
    function automatic logic [DW:0] bus_match(
        input logic [DW-1:0]   tag,
        input logic [4:0]      live,
        input logic [5*TW-1:0] dsts,
        input logic [5*DW-1:0] rslts
    );
        logic [DW:0] r;
        r = '0;
        for (int b = 4; b >= 0; b--) begin
            if (live[b] && tag[DW-1:TW] == '0 &&
                dsts[b*TW +: TW] == tag[TW-1:0]) begin
                r = {1'b1, rslts[b*DW +: DW]};
            end
        end
        return r;
    endfunction

    logic [DW:0] w1 [ENTRY_NUM];
    logic [DW:0] w2 [ENTRY_NUM];
    logic [DW:0] aw1;
    logic [DW:0] aw2;

    // Wakeup matches for stored operands and for the incoming allocation.
    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w1[i] = bus_match(src1[i], bus_live, bus_dst, bus_rslt);
            w2[i] = bus_match(src2[i], bus_live, bus_dst, bus_rslt);
        end
        aw1 = bus_match(alloc_src1, bus_live, bus_dst, bus_rslt);
        aw2 = bus_match(alloc_src2, bus_live, bus_dst, bus_rslt);
    end

    logic [ENTRY_SEL-1:0] free_idx;

    // Lowest-index free slot, from registered busy only.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = i[ENTRY_SEL-1:0];
        end
    end

    logic [ENTRY_NUM-1:0] cand;
    logic [ENTRY_SEL-1:0] sel_idx;
    logic                 alloc_fire;
    logic                 issue_fire;

    assign cand = busy & rdy1 & rdy2;

`ifdef RS_OLDEST_FIRST_EN
    // older[i][j] set means entry i was allocated before entry j.
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] older;
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] older_nxt;
    logic [ENTRY_NUM-1:0]                blocked;

    // Pick the single candidate with no older candidate.
    always_comb begin
        sel_idx = '0;
        blocked = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            for (int j = 0; j < ENTRY_NUM; j++) begin
                if (cand[j] && older[j][i]) blocked[i] = 1'b1;
            end
        end
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (cand[i] && !blocked[i]) sel_idx = i[ENTRY_SEL-1:0];
        end
    end

    // New entries are younger than all busy ones; issue drops its row/column.
    always_comb begin
        older_nxt = older;
        if (alloc_fire) begin
            for (int j = 0; j < ENTRY_NUM; j++) begin
                older_nxt[j][free_idx] = busy[j];
                older_nxt[free_idx][j] = 1'b0;
            end
        end
        if (issue_fire) begin
            for (int j = 0; j < ENTRY_NUM; j++) begin
                older_nxt[sel_idx][j] = 1'b0;
                older_nxt[j][sel_idx] = 1'b0;
            end
        end
    end

    // Age matrix register; flush forgets all ordering.
    always_ff @(posedge clk) begin
        if (!reset_x || flush) older <= '0;
        else                   older <= older_nxt;
    end
`else
    // Lowest-index ready entry.
    always_comb begin
        sel_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (cand[i]) sel_idx = i[ENTRY_SEL-1:0];
        end
    end
`endif

    assign alloc_rdy  = reset_x & ~flush & (count_q < CNT_FULL);
    assign iss_vld    = (|cand) & ~flush & reset_x;
    assign alloc_fire = alloc_vld & alloc_rdy;
    assign issue_fire = iss_vld & iss_rdy;

    assign iss_src1    = src1[sel_idx];
    assign iss_src2    = src2[sel_idx];
    assign iss_dst     = dst[sel_idx];
    assign iss_payload = pay[sel_idx];
    assign count       = count_q;

    // Entry state: wakeup capture, issue release and allocation write.
    always_ff @(posedge clk) begin
        if (!reset_x || flush) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (busy[i] && !rdy1[i] && w1[i][DW]) begin
                    rdy1[i] <= 1'b1;
                    src1[i] <= w1[i][DW-1:0];
                end
                if (busy[i] && !rdy2[i] && w2[i][DW]) begin
                    rdy2[i] <= 1'b1;
                    src2[i] <= w2[i][DW-1:0];
                end
            end
            if (issue_fire) busy[sel_idx] <= 1'b0;
            if (alloc_fire) begin
                busy[free_idx] <= 1'b1;
                rdy1[free_idx] <= alloc_rdy1 | aw1[DW];
                rdy2[free_idx] <= alloc_rdy2 | aw2[DW];
                src1[free_idx] <= (!alloc_rdy1 && aw1[DW]) ?
                                  aw1[DW-1:0] : alloc_src1;
                src2[free_idx] <= (!alloc_rdy2 && aw2[DW]) ?
                                  aw2[DW-1:0] : alloc_src2;
                dst[free_idx]  <= alloc_dst;
                pay[free_idx]  <= alloc_payload;
            end
        end
    end

    // Occupancy counter tracking allocate and issue handshakes.
    always_ff @(posedge clk) begin
        if (!reset_x || flush) begin
            count_q <= '0;
        end else begin
            case ({alloc_fire, issue_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Randomized scoreboard bench for rs_issue_ctrl.
// Honours RS_OLDEST_FIRST_EN when choosing the expected issue order.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module tb_rs_issue_ctrl;
    localparam int N  = 8;
    localparam int DW = `DATA_LEN;
    localparam int TW = `RRF_SEL;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          reset_x, flush, alloc_vld, alloc_rdy;
    logic [DW-1:0] alloc_src1, alloc_src2;
    logic          alloc_rdy1, alloc_rdy2;
    logic [TW-1:0] alloc_dst;
    logic [PW-1:0] alloc_payload;
    logic [DW-1:0] br [5];
    logic [TW-1:0] bd [5];
    logic          bk [5];
    logic          iss_vld, iss_rdy;
    logic [DW-1:0] iss_src1, iss_src2;
    logic [TW-1:0] iss_dst;
    logic [PW-1:0] iss_payload;
    logic [3:0]    count;

    always #5 clk = ~clk;

    rs_issue_ctrl #(.ENTRY_NUM(N), .ENTRY_SEL(3), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset_x(reset_x), .flush(flush),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy),
        .alloc_src1(alloc_src1), .alloc_rdy1(alloc_rdy1),
        .alloc_src2(alloc_src2), .alloc_rdy2(alloc_rdy2),
        .alloc_dst(alloc_dst), .alloc_payload(alloc_payload),
        .exrslt1(br[0]), .exrslt2(br[1]), .exrslt3(br[2]),
        .exrslt4(br[3]), .exrslt5(br[4]),
        .exdst1(bd[0]), .exdst2(bd[1]), .exdst3(bd[2]),
        .exdst4(bd[3]), .exdst5(bd[4]),
        .kill_spec1(bk[0]), .kill_spec2(bk[1]), .kill_spec3(bk[2]),
        .kill_spec4(bk[3]), .kill_spec5(bk[4]),
        .iss_vld(iss_vld), .iss_rdy(iss_rdy),
        .iss_src1(iss_src1), .iss_src2(iss_src2),
        .iss_dst(iss_dst), .iss_payload(iss_payload),
        .count(count)
    );

    typedef struct {
        bit            busy;
        bit            r1, r2;
        logic [DW-1:0] v1, v2;
        logic [TW-1:0] dst;
        logic [PW-1:0] pl;
        int            seq;
    } ent_t;

    typedef struct {
        logic [DW-1:0] s1, s2;
        logic [TW-1:0] dst;
        logic [PW-1:0] pl;
    } iss_t;

    typedef struct {
        int cnt;
        bit ardy;
        bit ivld;
    } stat_t;

    ent_t  m [N];
    iss_t  iss_q [$];
    stat_t stat_q [$];
    int    tests = 0;
    int    fails = 0;
    int    seq_ctr = 0;
    bit    done = 0;

    // A not-ready operand is a zero-extended tag; first live bus wins.
    function automatic bit wake(input logic [DW-1:0] tag,
                                output logic [DW-1:0] val);
        val = '0;
        if (tag[DW-1:TW] != '0) return 0;
        for (int b = 0; b < 5; b++) begin
            if (!bk[b] && bd[b] == tag[TW-1:0]) begin
                val = br[b];
                return 1;
            end
        end
        return 0;
    endfunction

    function automatic logic [DW-1:0] mk_op(input bit rdy);
        logic [DW-1:0] v;
        if (rdy) v = $urandom;
        else v = DW'($urandom_range(1, 12));
        return v;
    endfunction

    task automatic drive(input int cyc);
        int mode, pa, pi;
        mode = (cyc / 150) % 3;
        pa = (mode == 0) ? 60 : (mode == 1) ? 90 : 20;
        pi = (mode == 0) ? 60 : (mode == 1) ? 10 : 90;
        reset_x = !(cyc < 2 || $urandom_range(0, 299) == 0);
        flush = ($urandom_range(0, 39) == 0);
        alloc_vld = ($urandom_range(0, 99) < pa);
        alloc_rdy1 = ($urandom_range(0, 2) != 0);
        alloc_rdy2 = ($urandom_range(0, 2) != 0);
        alloc_src1 = mk_op(alloc_rdy1);
        alloc_src2 = mk_op(alloc_rdy2);
        alloc_dst = TW'($urandom);
        alloc_payload = $urandom;
        for (int b = 0; b < 5; b++) begin
            br[b] = $urandom;
            bd[b] = TW'($urandom_range(0, 12));
            bk[b] = ($urandom_range(0, 3) == 0);
        end
        iss_rdy = ($urandom_range(0, 99) < pi);
    endtask

    // Reference behaviour for one cycle: predict outputs, then advance.
    task automatic model_step();
        int nb, best, fs;
        bit ardy, ivld, h;
        logic [DW-1:0] v;
        stat_t st;
        iss_t it;
        nb = 0;
        best = -1;
        fs = -1;
        for (int i = 0; i < N; i++) begin
            if (m[i].busy) nb++;
            else if (fs < 0) fs = i;
            if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef RS_OLDEST_FIRST_EN
                if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        ardy = reset_x && !flush && nb < N;
        ivld = best >= 0 && !flush && reset_x;
        st.cnt = nb;
        st.ardy = ardy;
        st.ivld = ivld;
        stat_q.push_back(st);
        if (!reset_x || flush) begin
            for (int i = 0; i < N; i++) m[i].busy = 0;
            return;
        end
        if (ivld && iss_rdy) begin
            it.s1 = m[best].v1;
            it.s2 = m[best].v2;
            it.dst = m[best].dst;
            it.pl = m[best].pl;
            iss_q.push_back(it);
        end
        for (int i = 0; i < N; i++) begin
            if (!m[i].busy) continue;
            if (!m[i].r1) begin
                h = wake(m[i].v1, v);
                if (h) begin m[i].r1 = 1; m[i].v1 = v; end
            end
            if (!m[i].r2) begin
                h = wake(m[i].v2, v);
                if (h) begin m[i].r2 = 1; m[i].v2 = v; end
            end
        end
        if (ivld && iss_rdy) m[best].busy = 0;
        if (alloc_vld && ardy) begin
            m[fs].busy = 1;
            m[fs].dst = alloc_dst;
            m[fs].pl = alloc_payload;
            m[fs].seq = seq_ctr++;
            m[fs].r1 = alloc_rdy1;
            m[fs].v1 = alloc_src1;
            m[fs].r2 = alloc_rdy2;
            m[fs].v2 = alloc_src2;
            if (!alloc_rdy1 && wake(alloc_src1, v)) begin
                m[fs].r1 = 1; m[fs].v1 = v;
            end
            if (!alloc_rdy2 && wake(alloc_src2, v)) begin
                m[fs].r2 = 1; m[fs].v2 = v;
            end
        end
    endtask

    // Monitor: pops predictions and compares against what the DUT shows.
    initial begin
        stat_t st;
        iss_t it;
        while (!done) begin
            @(negedge clk);
            #2;
            if (stat_q.size() > 0) begin
                st = stat_q.pop_front();
                tests++;
                if (int'(count) != st.cnt) begin
                    fails++;
                    $display("FAIL count: got %0d want %0d at %0t",
                             count, st.cnt, $time);
                end
                tests++;
                if (alloc_rdy !== st.ardy) begin
                    fails++;
                    $display("FAIL alloc_rdy: got %b want %b at %0t",
                             alloc_rdy, st.ardy, $time);
                end
                tests++;
                if (iss_vld !== st.ivld) begin
                    fails++;
                    $display("FAIL iss_vld: got %b want %b at %0t",
                             iss_vld, st.ivld, $time);
                end
            end
            if (iss_vld === 1'b1 && iss_rdy && reset_x && !flush) begin
                tests++;
                if (iss_q.size() == 0) begin
                    fails++;
                    $display("FAIL issue: unexpected issue dst %0d at %0t",
                             iss_dst, $time);
                end else begin
                    it = iss_q.pop_front();
                    if (iss_src1 !== it.s1 || iss_src2 !== it.s2 ||
                        iss_dst !== it.dst || iss_payload !== it.pl) begin
                        fails++;
                        $display({"FAIL issue: got %h/%h/%0d/%h ",
                                  "want %h/%h/%0d/%h at %0t"},
                                 iss_src1, iss_src2, iss_dst, iss_payload,
                                 it.s1, it.s2, it.dst, it.pl, $time);
                    end
                end
            end
        end
    end

    // Stimulus: random traffic in alternating fill/drain phases.
    initial begin
        reset_x = 0;
        flush = 0;
        alloc_vld = 0;
        alloc_rdy1 = 0;
        alloc_rdy2 = 0;
        alloc_src1 = '0;
        alloc_src2 = '0;
        alloc_dst = '0;
        alloc_payload = '0;
        iss_rdy = 0;
        for (int b = 0; b < 5; b++) begin
            br[b] = '0;
            bd[b] = '0;
            bk[b] = 1'b1;
        end
        for (int i = 0; i < N; i++) m[i].busy = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive(c);
            #1;
            model_step();
        end
        @(negedge clk);
        reset_x = 0;
        flush = 0;
        alloc_vld = 0;
        iss_rdy = 0;
        repeat (2) @(negedge clk);
        done = 1;
        #3;
        tests++;
        if (iss_q.size() != 0) begin
            fails++;
            $display("FAIL missing_issues: got %0d left want 0",
                     iss_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
